// File: rtl/prewish_pkg.sv
// prewish_pkg: shared state encoding and pattern constants for the prewish mentor/blinky link
package prewish_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  localparam int PAT_WIDTH = 8;
  localparam logic [2:0] PAT_MSB = 3'd7;
endpackage

// File: rtl/prewish_prescaler.sv
// prewish_prescaler: free-running per-bit hold counter with clear and terminal-count strobe
module prewish_prescaler #(
  parameter int WIDTH = 21
) (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + WIDTH'(1) : cnt_q;
  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tc = en & (&cnt_q);
endmodule

// File: rtl/prewish_blinker.sv
// prewish_blinker: accepts an 8-bit pattern on a strobe edge and plays it MSB first on the LED
module prewish_blinker
  import prewish_pkg::*;
#(
  parameter int PRESCALE_BITS = 21
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 STB_I,
  input  logic [PAT_WIDTH-1:0] DAT_I,
  output logic                 ACK_O,
  output logic                 o_led,
  output logic                 o_busy
);
  state_e               state_q, state_d;
  logic [PAT_WIDTH-1:0] mask_q, mask_d;
  logic [2:0]           idx_q, idx_d;
  logic                 stb_prev_q, ack_q, ack_d, accept, tc;

  assign accept = STB_I & ~stb_prev_q;

  prewish_prescaler #(.WIDTH(PRESCALE_BITS)) u_prescaler (
    .CLK_I(CLK_I),
    .RST_I(RST_I),
    .clr  (accept),
    .en   (state_q == RUN),
    .tc   (tc)
  );

  // accept outranks the terminal count so a new pattern always restarts at the MSB
  always_comb begin
    state_d = accept ? ((DAT_I != '0) ? RUN : IDLE) : state_q;
    mask_d  = accept ? DAT_I : mask_q;
    idx_d   = accept ? PAT_MSB : tc ? idx_q - 3'd1 : idx_q;
    ack_d   = accept;
  end

  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      idx_q      <= PAT_MSB;
      stb_prev_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      idx_q      <= idx_d;
      stb_prev_q <= STB_I;
      ack_q      <= ack_d;
    end

  assign ACK_O  = ack_q;
  assign o_busy = (state_q == RUN);
  assign o_led  = o_busy & mask_q[idx_q];
endmodule

// File: tb/tb_prewish_blinker.sv
// tb_prewish_blinker: scoreboard bench for prewish_blinker with 4-cycle bit slots
module tb_prewish_blinker;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stb = 1'b0;
  logic [7:0] dat = 8'h00;
  logic       ack, led, busy;
  int         n_vec = 0;
  int         n_err = 0;

  typedef struct {
    string tag;
    logic  led;
    logic  busy;
    logic  ack;
  } exp_t;
  exp_t exp_q[$];

  prewish_blinker #(.PRESCALE_BITS(2)) dut (
    .CLK_I (clk),
    .RST_I (rst_n),
    .STB_I (stb),
    .DAT_I (dat),
    .ACK_O (ack),
    .o_led (led),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, ".led"}, led, e.led);
      chk({e.tag, ".busy"}, busy, e.busy);
      chk({e.tag, ".ack"}, ack, e.ack);
    end

  task automatic step(input string tag, input logic s, input logic [7:0] d,
                      input logic e_led, input logic e_busy, input logic e_ack);
    exp_t e;
    stb = s;
    dat = d;
    e.tag = tag; e.led = e_led; e.busy = e_busy; e.ack = e_ack;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // cycle c counts negedges after the accepting edge; bit 7-(c/4)%8 is on display
  task automatic play(input string tag, input logic [7:0] p, input int n, input int hold);
    for (int c = 0; c < n; c++) begin
      int b;
      b = 7 - ((c / 4) % 8);
      step(tag, c < hold, p, (p != 8'h00) & p[b], p != 8'h00, c == 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) step("in_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) step("idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    play("basic", 8'b1011_0100, 40, 1);
    step("gap", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    play("held", 8'hF0, 34, 10);
    play("pre_ff", 8'hFF, 10, 1);
    play("pre_01", 8'h01, 36, 1);
    play("run_aa", 8'hAA, 10, 1);
    play("zero", 8'h00, 20, 1);
    play("rst_aa", 8'hAA, 9, 1);
    chk("pre_rst.led", led, 1'b1);
    chk("pre_rst.busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.led", led, 1'b0);
    chk("async_rst.busy", busy, 1'b0);
    chk("async_rst.ack", ack, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step("post_rst", 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    play("restart", 8'h81, 8, 1);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
